// File: rtl/dual_bank_memory.sv
// Two equal-sized register banks sharing one address bus, with a power-up clear
// sequence that zeroes every word before accesses are accepted.
module dual_bank_memory #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  m_sel,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   bank0 [DEPTH];
  logic [DATA_WIDTH-1:0]   bank1 [DEPTH];
  logic                    wr0;
  logic                    wr1;

  always_comb begin
    wr0 = (state == ACTIVE) && w_en && !m_sel;
    wr1 = (state == ACTIVE) && w_en &&  m_sel;
  end

  // Storage carries no reset so it can map onto RAM; the clear walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      bank0[clr_cnt] <= '0;
      bank1[clr_cnt] <= '0;
    end else begin
      if (wr0) bank0[addr] <= data_in;
      if (wr1) bank1[addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      data1_o <= '0;
      data2_o <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          data1_o <= '0;
          data2_o <= '0;
          if (clr_cnt == LAST_ADDR) begin
            state <= ACTIVE;
            ready <= 1'b1;
          end
        end
        ACTIVE: begin
          ready   <= 1'b1;
          // A write to the selected bank is forwarded straight to its output.
          data1_o <= wr0 ? data_in : bank0[addr];
          data2_o <= wr1 ? data_in : bank1[addr];
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_bank_memory.sv
// Scoreboard bench for dual_bank_memory: a driver pushes the expected outputs of
// each edge, a monitor pops and compares them just after that edge.
module tb_dual_bank_memory;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          w_en;
  logic          m_sel;
  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;
  logic          ready;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          rdy;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] model_b0 [DEPTH];
  logic [DW-1:0] model_b1 [DEPTH];
  int            model_edges;
  int            compared;
  int            mismatched;

  dual_bank_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data_in (data_in),
    .w_en    (w_en),
    .m_sel   (m_sel),
    .data1_o (data1_o),
    .data2_o (data2_o),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after reset the banks are logically all zero; the first
  // DEPTH edges are the clear phase, after which writes land and reads see them.
  task automatic modelReset();
    model_edges = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_b0[i] = '0;
      model_b1[i] = '0;
    end
    sb.delete();
  endtask

  task automatic applyStimulus(input logic we, input logic sel, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    exp_t e;
    w_en    = we;
    m_sel   = sel;
    addr    = a;
    data_in = d;
    model_edges++;
    if (model_edges <= DEPTH) begin
      e.d1  = '0;
      e.d2  = '0;
      e.rdy = (model_edges == DEPTH);
    end else begin
      if (we && !sel) model_b0[a] = d;
      if (we &&  sel) model_b1[a] = d;
      e.d1  = model_b0[a];
      e.d2  = model_b1[a];
      e.rdy = 1'b1;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("data1_o", 32'(data1_o), 32'(e.d1));
      checkOutput("data2_o", 32'(data2_o), 32'(e.d2));
      checkOutput("ready",   32'(ready),   32'(e.rdy));
    end
  end

  task automatic midCycleReset();
    w_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_data1_o", 32'(data1_o), 32'd0);
    checkOutput("rst_data2_o", 32'(data2_o), 32'd0);
    checkOutput("rst_ready",   32'(ready),   32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runClear(input bool_poke);
    for (int i = 1; i <= DEPTH; i++) begin
      if (bool_poke && i == 5) applyStimulus(1'b1, 1'b0, '0, 9'h1FF);
      else applyStimulus(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                         DW'($urandom));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    w_en       = 1'b0;
    m_sel      = 1'b0;
    addr       = '0;
    data_in    = '0;
    modelReset();
    #3;
    checkOutput("init_data1_o", 32'(data1_o), 32'd0);
    checkOutput("init_data2_o", 32'(data2_o), 32'd0);
    checkOutput("init_ready",   32'(ready),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a clear part-way, then run a full clear with a write poked in at edge 5.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, AW'(i), '0);
    midCycleReset();
    runClear(1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, '0);

    applyStimulus(1'b1, 1'b0, 4'd3, 9'd10);
    applyStimulus(1'b0, 1'b0, 4'd3, '0);
    applyStimulus(1'b0, 1'b1, 4'd3, '0);
    applyStimulus(1'b1, 1'b1, 4'd3, 9'h155);
    applyStimulus(1'b0, 1'b0, 4'd3, '0);
    applyStimulus(1'b0, 1'b0, 4'd4, '0);
    applyStimulus(1'b1, 1'b1, 4'd3, 9'h0AA);
    applyStimulus(1'b1, 1'b1, 4'd3, 9'h1C3);
    applyStimulus(1'b0, 1'b0, 4'd3, '0);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, AW'(i), DW'(i));
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b0, 1'b0, AW'(i % DEPTH), '0);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));

    midCycleReset();
    runClear(1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, AW'(i), '0);
    for (int i = 0; i < 100; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
